// File: rtl/hasti_sram_slave_pkg.sv
// Shared HASTI bus encodings and the SRAM slave state machine type.
package pk_hasti;

    localparam logic [1:0] HTRANS_IDLE   = 2'd0;
    localparam logic [1:0] HTRANS_BUSY   = 2'd1;
    localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
    localparam logic [1:0] HTRANS_SEQ    = 2'd3;

    localparam logic [2:0] HSIZE_B = 3'd0;
    localparam logic [2:0] HSIZE_H = 3'd1;
    localparam logic [2:0] HSIZE_W = 3'd2;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_LAST,
        ST_ERR1,
        ST_ERR2
    } state_t;

    // Little-endian byte lanes touched by an aligned transfer.
    function automatic logic [3:0] byte_lanes(input logic [2:0] size, input logic [1:0] lo);
        logic [3:0] lanes;
        case (size)
            HSIZE_B: lanes = 4'b0001 << lo;
            HSIZE_H: lanes = lo[1] ? 4'b1100 : 4'b0011;
            default: lanes = 4'b1111;
        endcase
        return lanes;
    endfunction

endpackage

// File: rtl/hasti_sram_slave_array.sv
// Word-organised RAM with per-byte write enables and asynchronous read.
module hasti_sram_array #(
    parameter int DEPTH_WORDS = 1024,
    localparam int IDX_W = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic [3:0]       we,
    input  logic [IDX_W-1:0] addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/hasti_sram_slave.sv
// HASTI (AHB-Lite) SRAM responder with configurable wait states and
// two-cycle ERROR responses for oversize, misaligned or out-of-range accesses.
module hasti_sram_slave
    import pk_hasti::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic                  hclk,
    input  logic                  hresetn,
    input  logic                  hsel,
    input  logic [ADDR_WIDTH-1:0] haddr,
    input  logic                  hwrite,
    input  logic [2:0]            hsize,
    input  logic [2:0]            hburst,
    input  logic [3:0]            hprot,
    input  logic [1:0]            htrans,
    input  logic                  hmastlock,
    input  logic [DATA_WIDTH-1:0] hwdata,
    input  logic                  hready,
    output logic [DATA_WIDTH-1:0] hrdata,
    output logic                  hreadyout,
    output logic                  hresp
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WS_LOAD = 4'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);

    state_t           state, state_nx;
    logic [3:0]       cnt, cnt_nx;
    logic [IDX_W+1:0] a_addr;
    logic             a_write;
    logic [2:0]       a_size;
    logic             a_err;

    logic             ready_int;
    logic             active;
    logic             take;
    logic             err_in;
    logic [3:0]       we;
    logic [31:0]      rdata;

    wire unused_ok = &{1'b0, hburst, hprot, hmastlock, HTRANS_IDLE, HTRANS_BUSY};

    assign active    = (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
    assign ready_int = !((state == ST_WAIT) || (state == ST_ERR1));
    // Only sample a new address phase when no data phase is being stretched.
    assign take      = hsel && hready && active && ready_int;

    assign err_in = (hsize > HSIZE_W)
                 || ((hsize == HSIZE_H) && haddr[0])
                 || ((hsize == HSIZE_W) && (haddr[1:0] != 2'b00))
                 || (haddr[ADDR_WIDTH-1:2] >= (ADDR_WIDTH-2)'(DEPTH_WORDS));

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state   <= ST_IDLE;
            cnt     <= 4'd0;
            a_addr  <= '0;
            a_write <= 1'b0;
            a_size  <= 3'd0;
            a_err   <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (take) begin
                a_addr  <= haddr[IDX_W+1:0];
                a_write <= hwrite;
                a_size  <= hsize;
                a_err   <= err_in;
            end
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        hresp    = HRESP_OKAY;
        we       = 4'b0000;
        hrdata   = '0;
        case (state)
            ST_WAIT: begin
                if (cnt == 4'd0) state_nx = ST_LAST;
                else             cnt_nx   = cnt - 4'd1;
            end
            ST_LAST: begin
                if (a_write && !a_err) we = byte_lanes(a_size, a_addr[1:0]);
                else if (!a_write)     hrdata = rdata;
                state_nx = ST_IDLE;
            end
            ST_ERR1: begin
                hresp    = HRESP_ERROR;
                state_nx = ST_ERR2;
            end
            ST_ERR2: begin
                hresp    = HRESP_ERROR;
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
        // A new transfer may start out of IDLE or the final cycle of any data phase.
        if (take) begin
            if (err_in) begin
                state_nx = ST_ERR1;
            end else if (WAIT_STATES > 0) begin
                state_nx = ST_WAIT;
                cnt_nx   = WS_LOAD;
            end else begin
                state_nx = ST_LAST;
            end
        end
    end

    assign hreadyout = ready_int;

    hasti_sram_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_array (
        .clk   (hclk),
        .we    (we),
        .addr  (a_addr[IDX_W+1:2]),
        .wdata (hwdata),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_hasti_sram_slave.sv
// Bench for hasti_sram_slave: one zero-wait and one three-wait instance on a shared bus.
module tb_hasti_sram_slave;
    import pk_hasti::*;

    logic        hclk = 1'b0;
    logic        hresetn;
    logic        hsel;
    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
    logic [1:0]  htrans;
    logic        hmastlock;
    logic [31:0] hwdata;
    int          cur;

    logic [31:0] rd0, rd1, rd_m;
    logic        ry0, ry1, ry_m;
    logic        rs0, rs1, rs_m;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] ref_mem [int];
    logic [31:0] exp_q [$];

    always #5 hclk = ~hclk;

    hasti_sram_slave #(.WAIT_STATES(0)) u_ws0 (
        .hclk(hclk), .hresetn(hresetn), .hsel(hsel && cur == 0), .haddr(haddr),
        .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot),
        .htrans(htrans), .hmastlock(hmastlock), .hwdata(hwdata), .hready(ry0),
        .hrdata(rd0), .hreadyout(ry0), .hresp(rs0)
    );

    hasti_sram_slave #(.WAIT_STATES(3)) u_ws3 (
        .hclk(hclk), .hresetn(hresetn), .hsel(hsel && cur == 1), .haddr(haddr),
        .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot),
        .htrans(htrans), .hmastlock(hmastlock), .hwdata(hwdata), .hready(ry1),
        .hrdata(rd1), .hreadyout(ry1), .hresp(rs1)
    );

    assign rd_m = (cur == 0) ? rd0 : rd1;
    assign ry_m = (cur == 0) ? ry0 : ry1;
    assign rs_m = (cur == 0) ? rs0 : rs1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int ws_of(input int c);
        return (c == 0) ? 0 : 3;
    endfunction

    function automatic bit model_err(input logic [31:0] a, input logic [2:0] s);
        if (s > 3'd2) return 1'b1;
        if ((a % (32'd1 << s)) != 0) return 1'b1;
        if ((a >> 2) >= 32'd1024) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int key_of(input logic [31:0] a);
        return cur * 4096 + int'(a >> 2);
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [2:0] s, input logic [31:0] wd);
        logic [31:0] word;
        logic [31:0] ba;
        word = ref_mem.exists(key_of(a)) ? ref_mem[key_of(a)] : 32'h0;
        for (int k = 0; k < 4; k++) begin
            ba = (a & ~32'd3) + 32'(k);
            if (ba >= a && ba < a + (32'd1 << s)) word[8*k +: 8] = wd[8*k +: 8];
        end
        ref_mem[key_of(a)] = word;
    endtask

    task automatic addr_phase(input logic [1:0] tr, input logic w, input logic [31:0] a, input logic [2:0] s);
        hsel      = 1'b1;
        htrans    = tr;
        hwrite    = w;
        haddr     = a;
        hsize     = s;
        hburst    = 3'($urandom_range(0, 7));
        hprot     = 4'($urandom_range(0, 15));
        hmastlock = 1'($urandom_range(0, 1));
    endtask

    task automatic idle_bus();
        hsel   = 1'($urandom_range(0, 1));
        htrans = HTRANS_IDLE;
        haddr  = $urandom;
        hwrite = 1'($urandom_range(0, 1));
    endtask

    task automatic data_phase(input logic [31:0] wd, output int ncyc, output logic f_ready,
                              output logic f_resp, output logic l_resp, output logic [31:0] rdat);
        hwdata  = wd;
        ncyc    = 0;
        f_ready = 1'b1;
        f_resp  = 1'b0;
        do begin
            @(negedge hclk);
            ncyc++;
            if (ncyc == 1) begin
                f_ready = ry_m;
                f_resp  = rs_m;
            end
        end while (!ry_m && ncyc < 40);
        l_resp = rs_m;
        rdat   = rd_m;
    endtask

    task automatic xfer(input logic w, input logic [31:0] a, input logic [2:0] s,
                        input logic [31:0] wd, input string tag, output logic [31:0] rdat);
        bit   e;
        int   ncyc;
        logic f_ready, f_resp, l_resp;
        e = model_err(a, s);
        addr_phase(HTRANS_NONSEQ, w, a, s);
        @(posedge hclk); #1;
        idle_bus();
        if (!e && !w) exp_q.push_back(ref_mem[key_of(a)]);
        data_phase(wd, ncyc, f_ready, f_resp, l_resp, rdat);
        check({tag, "_cycles"}, 32'(ncyc), e ? 32'd2 : 32'(ws_of(cur) + 1));
        check({tag, "_hresp"}, {31'd0, l_resp}, {31'd0, e});
        if (e) begin
            check({tag, "_err1_resp"}, {31'd0, f_resp}, 32'd1);
            check({tag, "_err1_ready"}, {31'd0, f_ready}, 32'd0);
        end
        if (!e && !w) check({tag, "_rdata"}, rdat, exp_q.pop_front());
        else          check({tag, "_rdata_zero"}, rdat, 32'h0);
        if (w && !e) model_write(a, s, wd);
        @(posedge hclk); #1;
    endtask

    // Second transfer is a word read whose address phase overlaps the first data phase.
    task automatic b2b(input logic w1, input logic [31:0] a1, input logic [31:0] wd1,
                       input logic [31:0] a2, input string tag);
        int          ncyc;
        logic        f_ready, f_resp, l_resp;
        logic [31:0] rdat;
        addr_phase(HTRANS_NONSEQ, w1, a1, HSIZE_W);
        @(posedge hclk); #1;
        addr_phase(HTRANS_NONSEQ, 1'b0, a2, HSIZE_W);
        if (!w1) exp_q.push_back(ref_mem[key_of(a1)]);
        data_phase(wd1, ncyc, f_ready, f_resp, l_resp, rdat);
        check({tag, "_first_cycles"}, 32'(ncyc), 32'(ws_of(cur) + 1));
        if (!w1) check({tag, "_first_rdata"}, rdat, exp_q.pop_front());
        if (w1) model_write(a1, HSIZE_W, wd1);
        @(posedge hclk); #1;
        idle_bus();
        exp_q.push_back(ref_mem[key_of(a2)]);
        data_phase($urandom, ncyc, f_ready, f_resp, l_resp, rdat);
        check({tag, "_second_cycles"}, 32'(ncyc), 32'(ws_of(cur) + 1));
        check({tag, "_second_rdata"}, rdat, exp_q.pop_front());
        check({tag, "_second_hresp"}, {31'd0, l_resp}, 32'd0);
        @(posedge hclk); #1;
    endtask

    initial begin
        logic [31:0] rdat;
        logic [31:0] a;
        logic [2:0]  s;
        int          kind;

        hresetn = 1'b0;
        cur     = 0;
        hwdata  = 32'h0;
        hburst  = 3'd0;
        hprot   = 4'd0;
        hmastlock = 1'b0;
        hsize   = HSIZE_W;
        idle_bus();
        repeat (2) @(posedge hclk);
        #1;
        check("reset_ready0", {31'd0, ry0}, 32'd1);
        check("reset_ready3", {31'd0, ry1}, 32'd1);
        check("reset_resp", {30'd0, rs0, rs1}, 32'd0);
        check("reset_rdata", rd0 | rd1, 32'h0);
        hresetn = 1'b1;
        @(posedge hclk); #1;

        for (int c = 0; c < 2; c++) begin
            cur = c;
            for (int wi = 0; wi < 16; wi++) xfer(1'b1, 32'(wi * 4), HSIZE_W, $urandom, "fill", rdat);
        end

        // Zero-wait instance: directed cases.
        cur = 0;
        xfer(1'b1, 32'h10, HSIZE_W, 32'hDEADBEEF, "w_deadbeef", rdat);
        xfer(1'b0, 32'h10, HSIZE_W, 32'h0, "r_deadbeef", rdat);
        check("deadbeef_const", rdat, 32'hDEADBEEF);
        xfer(1'b1, 32'h20, HSIZE_W, 32'h11223344, "w_base", rdat);
        xfer(1'b1, 32'h23, HSIZE_B, 32'hAA000000, "w_byte3", rdat);
        xfer(1'b0, 32'h20, HSIZE_W, 32'h0, "r_byte3", rdat);
        check("byte_lane_const", rdat, 32'hAA223344);
        b2b(1'b1, 32'h30, $urandom, 32'h30, "raw_b2b");
        xfer(1'b0, 32'h2, HSIZE_W, 32'h0, "misaligned", rdat);
        xfer(1'b1, 32'h1000, HSIZE_W, 32'hFFFFFFFF, "out_of_range", rdat);
        xfer(1'b0, 32'h0, HSIZE_W, 32'h0, "word0_intact", rdat);
        @(negedge hclk);
        check("idle_rdata_zero", rd_m, 32'h0);
        check("idle_ready", {31'd0, ry_m}, 32'd1);
        @(posedge hclk); #1;

        // Three-wait instance: latency, back-to-back and error.
        cur = 1;
        xfer(1'b0, 32'h0, HSIZE_W, 32'h0, "ws3_read", rdat);
        b2b(1'b0, 32'h0, 32'h0, 32'h4, "ws3_b2b");
        xfer(1'b1, 32'h6, HSIZE_H, 32'h12345678, "ws3_half_hi", rdat);
        xfer(1'b0, 32'h4, HSIZE_W, 32'h0, "ws3_half_chk", rdat);
        xfer(1'b1, 32'h5, HSIZE_H, 32'h0, "ws3_half_mis", rdat);

        // Reset in the middle of a stretched write must not commit it.
        addr_phase(HTRANS_NONSEQ, 1'b1, 32'h14, HSIZE_W);
        @(posedge hclk); #1;
        idle_bus();
        hwdata = ~ref_mem[key_of(32'h14)];
        @(negedge hclk);
        check("rst_pre_wait", {31'd0, ry_m}, 32'd0);
        hresetn = 1'b0;
        #2;
        check("rst_ready", {31'd0, ry_m}, 32'd1);
        check("rst_resp", {31'd0, rs_m}, 32'd0);
        check("rst_rdata", rd_m, 32'h0);
        @(posedge hclk); #1;
        hresetn = 1'b1;
        addr_phase(HTRANS_BUSY, 1'b1, 32'h14, HSIZE_W);
        @(negedge hclk);
        check("busy_ready", {31'd0, ry_m}, 32'd1);
        check("busy_resp", {31'd0, rs_m}, 32'd0);
        @(posedge hclk); #1;
        addr_phase(HTRANS_IDLE, 1'b0, 32'h14, HSIZE_W);
        @(negedge hclk);
        check("after_busy_ready", {31'd0, ry_m}, 32'd1);
        @(posedge hclk); #1;
        @(negedge hclk);
        check("after_idle_ready", {31'd0, ry_m}, 32'd1);
        @(posedge hclk); #1;
        idle_bus();
        xfer(1'b0, 32'h14, HSIZE_W, 32'h0, "rst_no_commit", rdat);

        // Randomized traffic against the reference model on both instances.
        for (int c = 0; c < 2; c++) begin
            cur = c;
            for (int n = 0; n < 40; n++) begin
                kind = $urandom_range(0, 9);
                case (kind)
                    0: begin s = HSIZE_W; a = 32'h1000 + 32'($urandom_range(0, 255)) * 4; end
                    1: begin s = HSIZE_H; a = 32'($urandom_range(0, 15)) * 4 + 32'd1 + 32'd2 * 32'($urandom_range(0, 1)); end
                    2: begin s = 3'($urandom_range(3, 7)); a = 32'($urandom_range(0, 63)); end
                    default: begin
                        s = 3'($urandom_range(0, 2));
                        a = 32'($urandom_range(0, 15)) * 4 + ((32'($urandom_range(0, 3)) >> s) << s);
                    end
                endcase
                xfer(1'($urandom_range(0, 1)), a, s, $urandom, "rand", rdat);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
